ras_ckpt_stack: RTL and testbench
=================================

Name: ras_ckpt_stack

Overview:
- Parametrised return-address stack with speculative checkpoint/restore. Successor to the fixed single-entry `ras_t` usage in the BPU.
- Sits beside the BHT in the BPU.
  - Decode of a CALL pushes the return address (pc+8).
  - A RET pops and supplies the predicted target.
- Each prediction carries a checkpoint. On a verify mispredict or pipeline flush, the stack is rolled back to that checkpoint.
- Adds configurable depth, address width and overflow mode, plus top-entry repair on restore.

Parameters:
- DEPTH, 8, number of entries; must be a power of two, at least 2.
- ADDR_W, 32, width of a stored return address.
- OVF_WRAP, 1, overflow mode. 1 = a push when full overwrites the oldest entry (circular). 0 = a push when full is dropped.
- PTR_W, $clog2(DEPTH), derived localparam.
- CNT_W, $clog2(DEPTH+1), derived localparam.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- push  in  1  CALL decoded: push push_addr.
- push_addr  in  ADDR_W  return address to push.
- pop  in  1  RET decoded: pop the top entry.
- top_valid  out  1  stack non-empty.
- top_data  out  ADDR_W  current top entry (predicted RET target).
- ckpt_ptr  out  PTR_W  snapshot of the top pointer.
- ckpt_cnt  out  CNT_W  snapshot of occupancy.
- ckpt_top  out  ADDR_W  snapshot of the top entry value.
- restore  in  1  roll back the stack to the supplied checkpoint.
- restore_ptr  in  PTR_W  checkpoint pointer to restore.
- restore_cnt  in  CNT_W  checkpoint occupancy to restore.
- restore_top  in  ADDR_W  checkpoint top value to restore.
- count  out  CNT_W  current occupancy.
- full  out  1  count == DEPTH.

Behaviour:
- State:
  - entries[DEPTH] of ADDR_W.
  - ptr (PTR_W), indexing the current top.
  - cnt (CNT_W).
- Reset: ptr=0, cnt=0, all entries=0.
  - top_valid=0, top_data=0, count=0, full=0.
  - ckpt_* = 0.
- Outputs are combinational from the registered state:
  - top_valid = (cnt != 0).
  - top_data = entries[ptr].
  - ckpt_ptr = ptr, ckpt_cnt = cnt, ckpt_top = entries[ptr].
- Update latency: one cycle. Effects of a push/pop in cycle N are visible on the outputs in cycle N+1.
- Priority (highest first): reset > restore > push/pop.
- restore=1:
  - ptr <= restore_ptr.
  - cnt <= restore_cnt.
  - entries[restore_ptr] <= restore_top.
  - push and pop are ignored in that cycle.
- push only:
  - If cnt < DEPTH: ptr <= ptr+1 (mod DEPTH), entries[ptr+1] <= push_addr, cnt <= cnt+1.
  - If cnt == DEPTH and OVF_WRAP=1: same pointer/entry update; cnt stays DEPTH; the oldest entry is overwritten.
  - If cnt == DEPTH and OVF_WRAP=0: no state change.
- pop only:
  - If cnt != 0: ptr <= ptr-1 (mod DEPTH), cnt <= cnt-1. The entry value is left intact, so a later restore re-exposes it.
  - If cnt == 0 (underflow): no state change.
- push and pop together (RET in the slot of a CALL, e.g. jalr used as return):
  - entries[ptr] <= push_addr.
  - ptr unchanged.
  - cnt <= (cnt==0 ? 1 : cnt).
- Pointer arithmetic wraps modulo DEPTH. cnt never exceeds DEPTH and never goes below 0.
- Restore with restore_cnt > DEPTH is illegal. The verification bench asserts it never occurs.
- Reset asserted mid-sequence clears the state in the same edge, regardless of push/pop/restore.

Decomposition:
- Shared package / cpu.svh additions:
  - `RAS_DEPTH default (8).
  - `RAS_OVF_WRAP default (1).
  - ras_ckpt_t struct {ptr, cnt, top} sized from `RAS_DEPTH, which is what ds_to_es_bus_t carries.
  - The existing ras_t remains the output view {valid, data}.
- No sub-module: storage is a flop array plus pointer/count control in a single always_ff with a combinational next-state block.

Test Plan:
- Reset, then push 0xBFC00010, 0xBFC00020 on consecutive cycles, then idle -> top_data=0xBFC00020, count=2. Pop -> top_data=0xBFC00010, count=1.
- DEPTH=4, OVF_WRAP=1: push 0x10,0x20,0x30,0x40,0x50 -> count=4, full=1, top=0x50. Four pops yield 0x50,0x40,0x30,0x20 on top_data before each pop, then top_valid=0.
- DEPTH=4, OVF_WRAP=0: push five values 0x10..0x50 -> top stays 0x40, count=4. The fifth push is dropped.
- Empty stack: pop -> count stays 0, top_valid=0, ptr unchanged. Then a simultaneous push 0x80+pop -> count=1, top=0x80.
- Rollback:
  - Push 0x100, 0x200; capture ckpt (cnt=2, top=0x200).
  - Pop, then push 0x300; then restore with the ckpt.
  - Expected next cycle: top=0x200, count=2. Pop -> top=0x100.
- restore, push and pop all asserted in one cycle -> the restore values win. Reset asserted together with restore -> count=0, top_valid=0.

Source files
------------

// File: rtl/ras_ckpt_stack_pkg.sv
// rtl/ras_ckpt_stack_pkg.sv - shared RAS sizing, checkpoint and output-view types
package ras_ckpt_stack_pkg;

  localparam int RAS_DEPTH    = 8;
  localparam int RAS_OVF_WRAP = 1;
  localparam int RAS_ADDR_W   = 32;
  localparam int RAS_PTR_W    = $clog2(RAS_DEPTH);
  localparam int RAS_CNT_W    = $clog2(RAS_DEPTH + 1);

  // Checkpoint carried alongside each prediction down the pipe
  typedef struct packed {
    logic [RAS_PTR_W-1:0]  ptr;
    logic [RAS_CNT_W-1:0]  cnt;
    logic [RAS_ADDR_W-1:0] top;
  } ras_ckpt_t;

  typedef struct packed {
    logic                  valid;
    logic [RAS_ADDR_W-1:0] data;
  } ras_t;

endpackage

// File: rtl/ras_ckpt_stack.sv
// rtl/ras_ckpt_stack.sv - return-address stack with speculative checkpoint/restore
module ras_ckpt_stack
  import ras_ckpt_stack_pkg::*;
#(
  parameter int DEPTH    = RAS_DEPTH,
  parameter int ADDR_W   = RAS_ADDR_W,
  parameter int OVF_WRAP = RAS_OVF_WRAP,
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic              pop,
  output logic              top_valid,
  output logic [ADDR_W-1:0] top_data,
  output logic [PTR_W-1:0]  ckpt_ptr,
  output logic [CNT_W-1:0]  ckpt_cnt,
  output logic [ADDR_W-1:0] ckpt_top,
  input  logic              restore,
  input  logic [PTR_W-1:0]  restore_ptr,
  input  logic [CNT_W-1:0]  restore_cnt,
  input  logic [ADDR_W-1:0] restore_top,
  output logic [CNT_W-1:0]  count,
  output logic              full
);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] entries [DEPTH];
  logic [PTR_W-1:0]  ptr_q, ptr_d, ptr_inc, ptr_dec;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              wr_en;
  logic [PTR_W-1:0]  wr_idx;
  logic [ADDR_W-1:0] wr_data;

  assign ptr_inc = ptr_q + PTR_W'(1);
  assign ptr_dec = ptr_q - PTR_W'(1);

  always_comb begin
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    wr_en   = 1'b0;
    wr_idx  = ptr_q;
    wr_data = push_addr;
    if (restore) begin
      // Top-entry repair: the slot may have been clobbered by wrong-path pushes
      ptr_d   = restore_ptr;
      cnt_d   = restore_cnt;
      wr_en   = 1'b1;
      wr_idx  = restore_ptr;
      wr_data = restore_top;
    end else if (push && pop) begin
      wr_en = 1'b1;
      if (cnt_q == '0) cnt_d = CNT_W'(1);
    end else if (push) begin
      if (cnt_q != CNT_FULL || OVF_WRAP != 0) begin
        ptr_d  = ptr_inc;
        wr_en  = 1'b1;
        wr_idx = ptr_inc;
        if (cnt_q != CNT_FULL) cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (pop) begin
      // Popped value stays in place so a later restore can re-expose it
      if (cnt_q != '0) begin
        ptr_d = ptr_dec;
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      if (wr_en) entries[wr_idx] <= wr_data;
    end
  end

  assign top_valid = (cnt_q != '0);
  assign top_data  = entries[ptr_q];
  assign ckpt_ptr  = ptr_q;
  assign ckpt_cnt  = cnt_q;
  assign ckpt_top  = entries[ptr_q];
  assign count     = cnt_q;
  assign full      = (cnt_q == CNT_FULL);

endmodule

// File: tb/tb_ras_ckpt_stack.sv
// tb/tb_ras_ckpt_stack.sv - directed self-checking bench for ras_ckpt_stack
module tb_ras_ckpt_stack;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        push = 1'b0;
  logic        pop = 1'b0;
  logic [31:0] push_addr = '0;
  logic        restore = 1'b0;
  logic [7:0]  rptr = '0;
  logic [7:0]  rcnt = '0;
  logic [31:0] rtop = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  logic        a_valid, w_valid, d_valid;
  logic [31:0] a_top, w_top, d_top, a_ctop, w_ctop, d_ctop;
  logic [2:0]  a_cptr;
  logic [1:0]  w_cptr, d_cptr;
  logic [3:0]  a_ccnt, a_count;
  logic [2:0]  w_ccnt, w_count, d_ccnt, d_count;
  logic        a_full, w_full, d_full;

  ras_ckpt_stack #(.DEPTH(8), .ADDR_W(32), .OVF_WRAP(1)) u_dut8 (
    .clk(clk), .reset(reset), .push(push), .push_addr(push_addr), .pop(pop),
    .top_valid(a_valid), .top_data(a_top), .ckpt_ptr(a_cptr), .ckpt_cnt(a_ccnt),
    .ckpt_top(a_ctop), .restore(restore), .restore_ptr(rptr[2:0]),
    .restore_cnt(rcnt[3:0]), .restore_top(rtop), .count(a_count), .full(a_full)
  );

  ras_ckpt_stack #(.DEPTH(4), .ADDR_W(32), .OVF_WRAP(1)) u_dut4w (
    .clk(clk), .reset(reset), .push(push), .push_addr(push_addr), .pop(pop),
    .top_valid(w_valid), .top_data(w_top), .ckpt_ptr(w_cptr), .ckpt_cnt(w_ccnt),
    .ckpt_top(w_ctop), .restore(restore), .restore_ptr(rptr[1:0]),
    .restore_cnt(rcnt[2:0]), .restore_top(rtop), .count(w_count), .full(w_full)
  );

  ras_ckpt_stack #(.DEPTH(4), .ADDR_W(32), .OVF_WRAP(0)) u_dut4d (
    .clk(clk), .reset(reset), .push(push), .push_addr(push_addr), .pop(pop),
    .top_valid(d_valid), .top_data(d_top), .ckpt_ptr(d_cptr), .ckpt_cnt(d_ccnt),
    .ckpt_top(d_ctop), .restore(restore), .restore_ptr(rptr[1:0]),
    .restore_cnt(rcnt[2:0]), .restore_top(rtop), .count(d_count), .full(d_full)
  );

  always @(posedge clk) begin
    if (restore && !reset) assert (rcnt <= 8'd4) else $error("illegal restore_cnt %0d", rcnt);
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic cyc(input logic p, input logic [31:0] a, input logic o);
    push = p; push_addr = a; pop = o;
    @(negedge clk);
    push = 1'b0; pop = 1'b0;
  endtask

  task automatic do_restore(input logic [7:0] p, input logic [7:0] c, input logic [31:0] t,
                            input logic ps, input logic [31:0] a, input logic pp);
    restore = 1'b1; rptr = p; rcnt = c; rtop = t;
    push = ps; push_addr = a; pop = pp;
    @(negedge clk);
    restore = 1'b0; push = 1'b0; pop = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  logic [31:0] exp_pop [4] = '{32'h50, 32'h40, 32'h30, 32'h20};

  initial begin
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst_valid", a_valid, 0);
    check("rst_top", a_top, 0);
    check("rst_count", a_count, 0);
    check("rst_full", a_full, 0);
    check("rst_cptr", a_cptr, 0);
    check("rst_ccnt", a_ccnt, 0);
    check("rst_ctop", a_ctop, 0);

    cyc(1, 32'hBFC00010, 0);
    cyc(1, 32'hBFC00020, 0);
    cyc(0, 0, 0);
    check("push2_top", a_top, 32'hBFC00020);
    check("push2_count", a_count, 2);
    check("push2_valid", a_valid, 1);
    cyc(0, 0, 1);
    check("pop1_top", a_top, 32'hBFC00010);
    check("pop1_count", a_count, 1);

    do_reset();
    for (int i = 1; i <= 5; i++) cyc(1, 32'(i * 16), 0);
    check("wrap_count", w_count, 4);
    check("wrap_full", w_full, 1);
    check("wrap_top", w_top, 32'h50);
    check("drop_top", d_top, 32'h40);
    check("drop_count", d_count, 4);
    check("drop_full", d_full, 1);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("wrap_pop%0d_top", i), w_top, exp_pop[i]);
      cyc(0, 0, 1);
    end
    check("wrap_empty_valid", w_valid, 0);
    check("wrap_empty_count", w_count, 0);

    do_reset();
    cyc(0, 0, 1);
    check("uflow_count", a_count, 0);
    check("uflow_valid", a_valid, 0);
    check("uflow_ptr", a_cptr, 0);
    cyc(1, 32'h80, 1);
    check("pp_empty_count", a_count, 1);
    check("pp_empty_top", a_top, 32'h80);
    check("pp_empty_ptr", a_cptr, 0);

    do_reset();
    cyc(1, 32'h100, 0);
    cyc(1, 32'h200, 0);
    check("ckpt_ptr", a_cptr, 2);
    check("ckpt_cnt", a_ccnt, 2);
    check("ckpt_top", a_ctop, 32'h200);
    cyc(0, 0, 1);
    cyc(1, 32'h300, 0);
    check("wrongpath_top", a_top, 32'h300);
    do_restore(8'd2, 8'd2, 32'h200, 0, 0, 0);
    check("restore_top", a_top, 32'h200);
    check("restore_count", a_count, 2);
    cyc(0, 0, 1);
    check("restore_pop_top", a_top, 32'h100);
    check("restore_pop_count", a_count, 1);

    do_restore(8'd3, 8'd3, 32'hABC, 1, 32'h999, 1);
    check("rst_prio_top", a_top, 32'hABC);
    check("rst_prio_count", a_count, 3);
    check("rst_prio_ptr", a_cptr, 3);

    reset = 1'b1;
    do_restore(8'd1, 8'd2, 32'h555, 1, 32'h777, 0);
    reset = 1'b0;
    check("reset_vs_restore_count", a_count, 0);
    check("reset_vs_restore_valid", a_valid, 0);
    check("reset_vs_restore_top", a_top, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
